// File: rtl/jesd_clk_div_bank.sv
// jesd_clk_div_bank: bank of runtime-programmable clock dividers for the
// JESD204 link layer. Each channel has its own ratio, phase and enable.
// New settings are held in a shadow register and take effect at a period
// boundary, so no runt pulse is produced. A SYSREF-style sync realigns all
// channels, and lock flags report channels that have run clean for a while.
module jesd_clk_div_bank #(
    parameter int                NUM_CH       = 4,
    parameter int                DIV_W        = 8,
    parameter int                DEFAULT_DIV  = 2,
    parameter logic [NUM_CH-1:0] DEFAULT_EN   = {NUM_CH{1'b1}},
    parameter int                LOCK_PERIODS = 4,
    localparam int               CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic              cfg_en,
    output logic              cfg_err,
    input  logic              sync_req,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] ch_locked,
    output logic              all_locked
);

    localparam int               LK_W     = (LOCK_PERIODS > 1) ? $clog2(LOCK_PERIODS + 1) : 1;
    localparam logic [LK_W-1:0]  LOCK_MAX = LK_W'(LOCK_PERIODS);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

    // Ratios below 2 cannot produce a clock; they are raised to 2.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    // A phase must be a legal counter value for the (already clamped) ratio.
    function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] p,
                                                      input logic [DIV_W-1:0] d);
        return (p >= d) ? (d - 1'b1) : p;
    endfunction

    // Period counter for lock detection saturates at the lock threshold.
    function automatic logic [LK_W-1:0] lock_inc(input logic [LK_W-1:0] c);
        return (c >= LOCK_MAX) ? LOCK_MAX : (c + 1'b1);
    endfunction

    // Active configuration
    logic [DIV_W-1:0]  div_q      [NUM_CH];
    logic [DIV_W-1:0]  div_d      [NUM_CH];
    logic [DIV_W-1:0]  phase_q    [NUM_CH];
    logic [DIV_W-1:0]  phase_d    [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;

    // Shadow configuration awaiting a period boundary
    logic [DIV_W-1:0]  sh_div_q   [NUM_CH];
    logic [DIV_W-1:0]  sh_div_d   [NUM_CH];
    logic [DIV_W-1:0]  sh_phase_q [NUM_CH];
    logic [DIV_W-1:0]  sh_phase_d [NUM_CH];
    logic [NUM_CH-1:0] sh_en_q, sh_en_d;
    logic [NUM_CH-1:0] pend_q, pend_d;

    // Counters and registered outputs
    logic [DIV_W-1:0]  cnt_q      [NUM_CH];
    logic [DIV_W-1:0]  cnt_d      [NUM_CH];
    logic [LK_W-1:0]   lock_q     [NUM_CH];
    logic [LK_W-1:0]   lock_d     [NUM_CH];
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              cfg_err_q, cfg_err_d;

    // Request decode
    logic [NUM_CH-1:0] ch_hit;
    logic              accept;
    logic [DIV_W-1:0]  new_div;
    logic [DIV_W-1:0]  new_phase;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] apply;

    // One-hot decode of the target channel; all zero when it is out of range.
    always_comb begin
        ch_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_hit[i] = (cfg_ch == CH_W'(i));
        end
    end

    // Handshake: a channel takes a new request only once its shadow is free;
    // out-of-range requests are always taken so they can be flagged.
    always_comb begin
        cfg_ready = ~|(ch_hit & pend_q);
        accept    = cfg_valid && cfg_ready;
        new_div   = clamp_div(cfg_div);
        new_phase = clamp_phase(cfg_phase, new_div);
    end

    // Period boundary detection and the decision to switch to the shadow config.
    // A disabled channel has no period to finish, so it switches right away;
    // a sync also forces the switch so all channels realign on the new settings.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i]  = en_q[i] && (cnt_q[i] == (div_q[i] - 1'b1));
            apply[i] = pend_q[i] && (sync_req || !en_q[i] || wrap[i]);
        end
    end

    // Next-state for every channel: apply beats sync beats normal counting.
    always_comb begin
        cfg_err_d = accept && !(|ch_hit);
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]      = div_q[i];
            phase_d[i]    = phase_q[i];
            en_d[i]       = en_q[i];
            sh_div_d[i]   = sh_div_q[i];
            sh_phase_d[i] = sh_phase_q[i];
            sh_en_d[i]    = sh_en_q[i];
            pend_d[i]     = pend_q[i];
            cnt_d[i]      = cnt_q[i];
            lock_d[i]     = lock_q[i];
            clk_out_d[i]  = en_q[i] && (cnt_q[i] < (div_q[i] >> 1));
            tick_d[i]     = en_q[i] && (cnt_q[i] == '0);

            if (apply[i]) begin
                div_d[i]   = sh_div_q[i];
                phase_d[i] = sh_phase_q[i];
                en_d[i]    = sh_en_q[i];
                cnt_d[i]   = sh_en_q[i] ? sh_phase_q[i] : '0;
                lock_d[i]  = '0;
                pend_d[i]  = 1'b0;
            end else if (!en_q[i]) begin
                cnt_d[i]  = '0;
                lock_d[i] = '0;
            end else if (sync_req) begin
                cnt_d[i]  = phase_q[i];
                lock_d[i] = '0;
            end else if (wrap[i]) begin
                cnt_d[i]  = '0;
                lock_d[i] = lock_inc(lock_q[i]);
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            // The shadow is free whenever a request is accepted for this channel,
            // so capturing here never collides with the apply above.
            if (accept && ch_hit[i]) begin
                sh_div_d[i]   = new_div;
                sh_phase_d[i] = new_phase;
                sh_en_d[i]    = cfg_en;
                pend_d[i]     = 1'b1;
            end
        end
    end

    // State registers; reset discards any pending request.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]      <= DIV_RST;
                phase_q[i]    <= '0;
                sh_div_q[i]   <= DIV_RST;
                sh_phase_q[i] <= '0;
                cnt_q[i]      <= '0;
                lock_q[i]     <= '0;
            end
            en_q      <= DEFAULT_EN;
            sh_en_q   <= DEFAULT_EN;
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]      <= div_d[i];
                phase_q[i]    <= phase_d[i];
                sh_div_q[i]   <= sh_div_d[i];
                sh_phase_q[i] <= sh_phase_d[i];
                cnt_q[i]      <= cnt_d[i];
                lock_q[i]     <= lock_d[i];
            end
            en_q      <= en_d;
            sh_en_q   <= sh_en_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Lock flags come straight from registers; a disabled channel holds its
    // lock counter at zero, and all_locked ignores disabled channels.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_locked[i] = (lock_q[i] == LOCK_MAX);
        end
        all_locked = (|en_q) && (&(ch_locked | ~en_q));
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign cfg_err = cfg_err_q;

endmodule
